// File: rtl/sr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module : sr_ctrl_pkg
//  Shared FSM state type and counter-width helper for the SR command stage.
//  Rev    : 1.0
// ============================================================================
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SET_ACT = 2'd1,
        CLR_ACT = 2'd2,
        GAP     = 2'd3
    } sr_state_t;

    // Bits needed to hold 0..n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage : sr_ctrl_pkg
`default_nettype wire

// File: rtl/sr_debounce.sv
`default_nettype none
// ============================================================================
//  Module : sr_debounce
//  Two-flop synchroniser, stability counter and rising-edge request pulse.
//  Rev    : 1.0
// ============================================================================
module sr_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int             c_cw    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [c_cw-1:0] c_limit = c_cw'(DEBOUNCE_CYCLES);
    localparam logic [c_cw-1:0] c_one   = c_cw'(1);

    logic [1:0]      r_sync;
    logic [c_cw-1:0] r_cnt;
    logic            r_level;
    logic            r_level_d;

    // The counter measures how long the synchronised input has disagreed
    // with the accepted level; any agreement restarts the measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b00;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_btn};
            r_level_d <= r_level;
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_limit) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + c_one;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_level & ~r_level_d;

endmodule : sr_debounce
`default_nettype wire

// File: rtl/sr_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : sr_request_arbiter
//  Debounced set/clear command arbiter feeding a synchronous SR stage.
//  Rev    : 1.0
// ============================================================================
module sr_request_arbiter
    import sr_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GAP_CYCLES      = 2,
    parameter int PULSE_MODE      = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic set_btn,
    input  logic clr_btn,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict
);

    localparam int             c_gw       = cnt_width(GAP_CYCLES);
    localparam logic [c_gw-1:0] c_gap_load = c_gw'(GAP_CYCLES);
    localparam logic [c_gw-1:0] c_gap_one  = c_gw'(1);

    logic w_set_level, w_set_rise;
    logic w_clr_level, w_clr_rise;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk     (clk),
        .rst     (reset),
        .i_btn   (set_btn),
        .o_level (w_set_level),
        .o_rise  (w_set_rise)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
        .clk     (clk),
        .rst     (reset),
        .i_btn   (clr_btn),
        .o_level (w_clr_level),
        .o_rise  (w_clr_rise)
    );

    sr_state_t       r_state, w_next;
    logic            r_pend_set, r_pend_clr;
    logic [c_gw-1:0] r_gap_cnt;
    logic            r_s, r_r, r_busy, r_conflict;

    logic            w_pend_set_n, w_pend_clr_n;
    logic [c_gw-1:0] w_gap_n;
    logic            w_conflict_n, w_decide;
    logic            w_req_set, w_req_clr;
    logic            w_s_n, w_r_n;

    assign w_req_set = w_set_rise | r_pend_set;
    assign w_req_clr = w_clr_rise | r_pend_clr;

    // w_decide marks a cycle in which the next command may be chosen:
    // plain IDLE, or the final ACT/GAP cycle so a pending request issues
    // without an intervening idle cycle.
    always_comb begin
        w_next       = r_state;
        w_pend_set_n = r_pend_set;
        w_pend_clr_n = r_pend_clr;
        w_gap_n      = r_gap_cnt;
        w_conflict_n = 1'b0;
        w_decide     = 1'b0;
        case (r_state)
            IDLE: w_decide = 1'b1;
            SET_ACT, CLR_ACT: begin
                if (GAP_CYCLES > 0) begin
                    w_next       = GAP;
                    w_gap_n      = c_gap_load;
                    w_pend_set_n = w_req_set;
                    w_pend_clr_n = w_req_clr;
                end else begin
                    w_decide = 1'b1;
                end
            end
            GAP: begin
                if (r_gap_cnt <= c_gap_one) begin
                    w_decide = 1'b1;
                end else begin
                    w_gap_n      = r_gap_cnt - c_gap_one;
                    w_pend_set_n = w_req_set;
                    w_pend_clr_n = w_req_clr;
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_decide) begin
            w_pend_set_n = 1'b0;
            w_pend_clr_n = 1'b0;
            if (w_req_set && w_req_clr) begin
                w_next       = IDLE;
                w_conflict_n = 1'b1;
            end else if (w_req_set) begin
                w_next = SET_ACT;
            end else if (w_req_clr) begin
                w_next = CLR_ACT;
            end else begin
                w_next = IDLE;
            end
        end
    end

    generate
        if (PULSE_MODE != 0) begin : g_pulse_out
            assign w_s_n = (w_next == SET_ACT);
            assign w_r_n = (w_next == CLR_ACT);
        end else begin : g_level_out
            // Each level holds until the opposite command, so s and r never overlap.
            assign w_s_n = (w_next == SET_ACT) | (r_s & (w_next != CLR_ACT));
            assign w_r_n = (w_next == CLR_ACT) | (r_r & (w_next != SET_ACT));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pend_set <= 1'b0;
            r_pend_clr <= 1'b0;
            r_gap_cnt  <= '0;
            r_s        <= 1'b0;
            r_r        <= 1'b0;
            r_busy     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_pend_set <= w_pend_set_n;
            r_pend_clr <= w_pend_clr_n;
            r_gap_cnt  <= w_gap_n;
            r_s        <= w_s_n;
            r_r        <= w_r_n;
            r_busy     <= (w_next != IDLE);
            r_conflict <= w_conflict_n;
        end
    end

    assign s        = r_s;
    assign r        = r_r;
    assign busy     = r_busy;
    assign conflict = r_conflict;

endmodule : sr_request_arbiter
`default_nettype wire

// File: tb/tb_sr_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module : tb_sr_request_arbiter
//  Self-checking bench for sr_request_arbiter, pulse and level output modes.
//  Rev    : 1.0
// ============================================================================
module tb_sr_request_arbiter;

    logic clk = 1'b0;
    logic reset, set_btn, clr_btn;
    logic s_p, r_p, busy_p, conf_p;
    logic s_l, r_l, busy_l, conf_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sr_request_arbiter #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2), .PULSE_MODE(1)) dut (
        .clk(clk), .reset(reset), .set_btn(set_btn), .clr_btn(clr_btn),
        .s(s_p), .r(r_p), .busy(busy_p), .conflict(conf_p)
    );

    sr_request_arbiter #(.DEBOUNCE_CYCLES(4), .GAP_CYCLES(2), .PULSE_MODE(0)) dut_lvl (
        .clk(clk), .reset(reset), .set_btn(set_btn), .clr_btn(clr_btn),
        .s(s_l), .r(r_l), .busy(busy_l), .conflict(conf_l)
    );

    typedef struct {
        string name;
        int    set_on, set_off, clr_on, clr_off;
        int    es, er, ec;
        int    b0l, b0h, b1l, b1h;
    } vec_t;

    typedef struct {
        string      tag;
        int         cyc;
        logic [3:0] ep;
        logic [3:0] el;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[7];

    // s & r must never both be high, in either mode
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            checks++;
            if ((s_p & r_p) !== 1'b0 || (s_l & r_l) !== 1'b0) begin
                errors++;
                $display("FAIL s_and_r t=%0t pulse s=%b r=%b level s=%b r=%b required s&r=0",
                         $time, s_p, r_p, s_l, r_l);
            end
        end
    end

    // Expected {s,r,busy,conflict} for pulse mode (ep) and level mode (el)
    function automatic exp_t expect_vec(input vec_t v, input int c);
        exp_t e;
        int   ls, lr;
        logic b;
        b  = (v.b0l > 0 && c >= v.b0l && c <= v.b0h) || (v.b1l > 0 && c >= v.b1l && c <= v.b1h);
        ls = (v.es > 0 && v.es <= c) ? v.es : 0;
        lr = (v.er > 0 && v.er <= c) ? v.er : 0;
        e.tag = v.name;
        e.cyc = c;
        e.ep  = {c == v.es, c == v.er, b, c == v.ec};
        e.el  = {ls > lr, lr > ls, b, c == v.ec};
        return e;
    endfunction

    task automatic run_cycle(input logic rs, input logic sb_in, input logic cb_in, input exp_t e);
        exp_t got;
        @(negedge clk);
        reset   = rs;
        set_btn = sb_in;
        clr_btn = cb_in;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checks++;
        if ({s_p, r_p, busy_p, conf_p} !== got.ep) begin
            errors++;
            $display("FAIL %s_pulse cyc=%0d got s,r,busy,conf=%b required %b",
                     got.tag, got.cyc, {s_p, r_p, busy_p, conf_p}, got.ep);
        end
        checks++;
        if ({s_l, r_l, busy_l, conf_l} !== got.el) begin
            errors++;
            $display("FAIL %s_level cyc=%0d got s,r,busy,conf=%b required %b",
                     got.tag, got.cyc, {s_l, r_l, busy_l, conf_l}, got.el);
        end
    endtask

    task automatic do_reset(input string tag);
        exp_t z;
        z.tag = {tag, "_reset"};
        z.ep  = 4'b0000;
        z.el  = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            z.cyc = i;
            run_cycle(1'b1, 1'b0, 1'b0, z);
        end
    endtask

    initial begin
        exp_t e;
        reset   = 1'b1;
        set_btn = 1'b0;
        clr_btn = 1'b0;

        //          name            son soff con coff  es  er  ec  b0l b0h b1l b1h
        vecs[0] = '{"set_hold",       1, 99, 99, 99,   8, -1, -1,   8, 10, -1, -1};
        vecs[1] = '{"set_glitch",     1,  4, 99, 99,  -1, -1, -1,  -1, -1, -1, -1};
        vecs[2] = '{"both_same",      1, 99,  1, 99,  -1, -1,  8,  -1, -1, -1, -1};
        vecs[3] = '{"clr_in_act",     1, 99,  2, 99,   8, 11, -1,   8, 13, -1, -1};
        vecs[4] = '{"clr_only",      99, 99,  3, 99,  -1, 10, -1,  10, 12, -1, -1};
        vecs[5] = '{"set_then_clr",   1, 12, 12, 99,   8, 19, -1,   8, 10, 19, 21};
        vecs[6] = '{"clr_in_gap",     1, 99,  3, 99,   8, 11, -1,   8, 13, -1, -1};

        foreach (vecs[k]) begin
            do_reset(vecs[k].name);
            for (int c = 1; c <= 28; c++) begin
                e = expect_vec(vecs[k], c);
                run_cycle(1'b0,
                          (c >= vecs[k].set_on && c < vecs[k].set_off),
                          (c >= vecs[k].clr_on && c < vecs[k].clr_off),
                          e);
            end
        end

        // Reset lands in GAP with a clear pending; clear button stays held
        // through reset and must produce exactly one fresh r afterwards.
        do_reset("rst_in_gap");
        for (int c = 1; c <= 28; c++) begin
            logic rs;
            rs    = (c == 10 || c == 11);
            e.tag = "rst_in_gap";
            e.cyc = c;
            e.ep  = {c == 8, c == 19, (c == 8 || c == 9 || (c >= 19 && c <= 21)), 1'b0};
            e.el  = {(c == 8 || c == 9), c >= 19, (c == 8 || c == 9 || (c >= 19 && c <= 21)), 1'b0};
            run_cycle(rs, (c < 9), (c >= 2), e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sr_request_arbiter
`default_nettype wire
